// File: rtl/spike_scan_filter_if.sv
// Bus bundle for spike_scan_filter: control, spike-time SRAM port and event FIFO port.
// spike_cnt_o exists only when SPIKE_SCAN_FILTER_CNT_EN is defined.
interface spike_scan_filter_if #(
  parameter int unsigned N      = 256,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned SLOT_W = 8
);
  localparam int unsigned SLOTS = WORD_W / SLOT_W;
  localparam int unsigned WORDS = N / SLOTS;
  localparam int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned IW    = $clog2(N);

  logic              start_i;
  logic [SLOT_W-1:0] tick_i;
  logic              next_tick_i;
  logic              mem_req_o;
  logic [AW-1:0]     mem_addr_o;
  logic [WORD_W-1:0] mem_rdata_i;
  logic              fifo_w_en_o;
  logic [IW-1:0]     fifo_w_data_o;
  logic              fifo_full_i;
  logic              busy_o;
  logic              done_o;
`ifdef SPIKE_SCAN_FILTER_CNT_EN
  logic [IW:0]       spike_cnt_o;
`endif

  modport master (
    input  start_i, tick_i, next_tick_i, mem_rdata_i, fifo_full_i,
    output mem_req_o, mem_addr_o, fifo_w_en_o, fifo_w_data_o, busy_o, done_o
`ifdef SPIKE_SCAN_FILTER_CNT_EN
    , output spike_cnt_o
`endif
  );

  modport slave (
    output start_i, tick_i, next_tick_i, mem_rdata_i, fifo_full_i,
    input  mem_req_o, mem_addr_o, fifo_w_en_o, fifo_w_data_o, busy_o, done_o
`ifdef SPIKE_SCAN_FILTER_CNT_EN
    , input spike_cnt_o
`endif
  );
endinterface

// File: rtl/spike_scan_filter.sv
// Scans the spike-time SRAM word by word and pushes every neuron whose slot equals the tick.
// Optional per-scan accepted-write counter enabled by SPIKE_SCAN_FILTER_CNT_EN.
module spike_scan_filter #(
  parameter int unsigned N      = 256,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned SLOT_W = 8
) (
  input logic            CLK,
  input logic            RST,
  spike_scan_filter_if.master bus
);
  localparam int unsigned SLOTS = WORD_W / SLOT_W;
  localparam int unsigned WORDS = N / SLOTS;
  localparam int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned IW    = $clog2(N);
  localparam int unsigned PSH   = $clog2(SLOTS);
  localparam int unsigned PW    = (SLOTS > 1) ? PSH : 1;

  typedef enum logic [2:0] {IDLE, REQ, CMP, PUSH, DONE} state_t;

  state_t           state;
  logic [AW-1:0]    word;
  logic [SLOTS-1:0] mask;
  logic [SLOTS-1:0] hit;
  logic [SLOTS-1:0] rest;
  logic [PW-1:0]    p;
  logic             mem_req;
  logic             busy;
  logic             done;
  logic             last_word;
  logic             accept;

  // Per-slot tick match on the word returned by the SRAM
  always_comb begin
    hit = '0;
    for (int k = 0; k < int'(SLOTS); k++) begin
      hit[k] = (bus.mem_rdata_i[k*SLOT_W +: SLOT_W] == bus.tick_i);
    end
  end

  // Lowest pending slot; scanning downward leaves the lowest index in p
  always_comb begin
    p = '0;
    for (int k = int'(SLOTS) - 1; k >= 0; k--) begin
      if (mask[k]) p = PW'(k);
    end
  end

  assign rest      = mask & (mask - SLOTS'(1));
  assign last_word = (word == AW'(WORDS - 1));
  assign accept    = (state == PUSH) && !bus.fifo_full_i;

  assign bus.fifo_w_en_o   = accept;
  assign bus.fifo_w_data_o = (IW'(word) << PSH) | IW'(p);
  assign bus.mem_req_o     = mem_req;
  assign bus.mem_addr_o    = word;
  assign bus.busy_o        = busy;
  assign bus.done_o        = done;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      word    <= '0;
      mask    <= '0;
      mem_req <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            state   <= REQ;
            word    <= '0;
            mem_req <= 1'b1;
            busy    <= 1'b1;
          end
        end
        REQ: begin
          state   <= CMP;
          mem_req <= 1'b0;
        end
        CMP: begin
          mask <= hit;
          if (hit != '0) begin
            state <= PUSH;
          end else if (last_word) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            word    <= word + AW'(1);
            state   <= REQ;
            mem_req <= 1'b1;
          end
        end
        PUSH: begin
          if (!bus.fifo_full_i) begin
            mask <= rest;
            if (rest == '0) begin
              if (last_word) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                word    <= word + AW'(1);
                state   <= REQ;
                mem_req <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (bus.next_tick_i) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPIKE_SCAN_FILTER_CNT_EN
  logic [IW:0] cnt;

  // Accepted writes in the current scan, saturating at N
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (state == IDLE && bus.start_i) begin
      cnt <= '0;
    end else if (accept && cnt != (IW+1)'(N)) begin
      cnt <= cnt + (IW+1)'(1);
    end
  end

  assign bus.spike_cnt_o = cnt;
`endif
endmodule

// File: tb/tb_spike_scan_filter.sv
// Self-checking bench for spike_scan_filter: directed table, reset-in-PUSH, random scans, wide config.
module tb_spike_scan_filter;
  localparam int unsigned N = 256, WORD_W = 32, SLOT_W = 8;
  localparam int unsigned SLOTS = 4, WORDS = 64;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  spike_scan_filter_if #(.N(N), .WORD_W(WORD_W), .SLOT_W(SLOT_W)) b1();
  spike_scan_filter #(.N(N), .WORD_W(WORD_W), .SLOT_W(SLOT_W)) dut (.CLK(CLK), .RST(RST), .bus(b1));

  spike_scan_filter_if #(.N(64), .WORD_W(64), .SLOT_W(16)) b2();
  spike_scan_filter #(.N(64), .WORD_W(64), .SLOT_W(16)) dut2 (.CLK(CLK), .RST(RST), .bus(b2));

  logic [31:0] mem1 [WORDS];
  logic [63:0] mem2 [16];

  // One-cycle-latency SRAM models
  always @(posedge CLK) if (b1.mem_req_o) b1.mem_rdata_i <= mem1[b1.mem_addr_o];
  always @(posedge CLK) if (b2.mem_req_o) b2.mem_rdata_i <= mem2[b2.mem_addr_o];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int got[$];
  int got_k[$];
  int expq[$];
  int reqs, done_k, viol, stall_bad, cnt_at_req;

  // Reference: every neuron whose stored spike time equals the tick, ascending
  function automatic void build_exp(input logic [7:0] t);
    logic [31:0] w;
    expq.delete();
    for (int i = 0; i < int'(N); i++) begin
      w = mem1[i / SLOTS];
      if (w[(i % SLOTS) * SLOT_W +: SLOT_W] == t) expq.push_back(i);
    end
  endfunction

  task automatic clear_mem1();
    for (int i = 0; i < int'(WORDS); i++) mem1[i] = 32'h0;
  endtask

  // mode 0: never full, 1: random full (pct) with stray start/next_tick, 2: full in cycles 3..6
  task automatic run_scan(input logic [7:0] t, input int mode, input int pct);
    got.delete(); got_k.delete();
    reqs = 0; done_k = 0; viol = 0; stall_bad = 0; cnt_at_req = -1;
    @(posedge CLK); #1;
    b1.start_i = 1'b1; b1.tick_i = t; b1.fifo_full_i = 1'b0;
    @(posedge CLK); #1;
    b1.start_i = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      case (mode)
        1:       b1.fifo_full_i = ($urandom_range(99) < pct);
        2:       b1.fifo_full_i = (k >= 3 && k <= 6);
        default: b1.fifo_full_i = 1'b0;
      endcase
      @(negedge CLK);
      if (b1.mem_req_o) reqs++;
      if (b1.fifo_w_en_o) begin
        got.push_back(int'(b1.fifo_w_data_o));
        got_k.push_back(k);
        if (b1.fifo_full_i) viol++;
      end
      if (mode == 2 && k >= 3 && k <= 6 && expq.size() > 0 &&
          (b1.fifo_w_en_o || int'(b1.fifo_w_data_o) != expq[0])) stall_bad++;
`ifdef SPIKE_SCAN_FILTER_CNT_EN
      if (k == 1) cnt_at_req = int'(b1.spike_cnt_o);
`endif
      if (b1.done_o) begin
        done_k = k;
        break;
      end
      if (mode == 1) begin
        b1.start_i     = ($urandom_range(3) == 0);
        b1.next_tick_i = ($urandom_range(3) == 0);
      end
      @(posedge CLK); #1;
    end
    b1.start_i = 1'b0; b1.next_tick_i = 1'b0; b1.fifo_full_i = 1'b0;
  endtask

  // Common post-scan checks, then release DONE; lat < 0 skips the latency check
  task automatic check_scan(input string nm, input int lat);
    int mm;
    chk({nm, " done_seen"}, (done_k != 0), 1);
    chk({nm, " req_count"}, reqs, WORDS);
    chk({nm, " write_while_full"}, viol, 0);
    chk({nm, " write_count"}, got.size(), expq.size());
    mm = 0;
    for (int i = 0; i < got.size() && i < expq.size(); i++) if (got[i] != expq[i]) mm++;
    chk({nm, " order"}, mm, 0);
    if (lat >= 0) chk({nm, " latency"}, done_k - 1, lat);
    repeat (3) @(negedge CLK);
    chk({nm, " done_held"}, b1.done_o, 1);
`ifdef SPIKE_SCAN_FILTER_CNT_EN
    chk({nm, " cnt_cleared"}, cnt_at_req, 0);
    chk({nm, " spike_cnt"}, int'(b1.spike_cnt_o), expq.size());
`endif
    b1.next_tick_i = 1'b1;
    @(posedge CLK); #1;
    b1.next_tick_i = 1'b0;
    @(negedge CLK);
    chk({nm, " idle_after_next"}, {b1.done_o, b1.busy_o}, 0);
  endtask

  typedef struct {
    string       name;
    int          widx;
    logic [31:0] wval;
    logic [7:0]  tick;
    int          mode;
    int          n;
    int          first;
    int          last;
    int          lat;
  } vec_t;

  vec_t tbl[6];
  int   m, nwr, wdata, req2, dk2;

  initial begin
    tbl[0] = '{"all_zero",   -1, 32'h0000_0000, 8'h05, 0,   0,  -1,  -1, 128};
    tbl[1] = '{"word3",       3, 32'h0500_0500, 8'h05, 0,   2,  13,  15, 130};
    tbl[2] = '{"stall",       0, 32'h0505_0505, 8'h05, 2,   4,   0,   3, 136};
    tbl[3] = '{"last_word",  63, 32'h05A1_B2C3, 8'h05, 0,   1, 255, 255, 129};
    tbl[4] = '{"tick_ff",    10, 32'hFFFF_FFFF, 8'hFF, 0,   4,  40,  43, 132};
    tbl[5] = '{"all_match",  -1, 32'h0000_0000, 8'h00, 0, 256,   0, 255, 384};

    RST = 1'b1;
    b1.start_i = 0; b1.tick_i = 0; b1.next_tick_i = 0; b1.fifo_full_i = 0; b1.mem_rdata_i = 0;
    b2.start_i = 0; b2.tick_i = 0; b2.next_tick_i = 0; b2.fifo_full_i = 0; b2.mem_rdata_i = 0;
    clear_mem1();
    for (int i = 0; i < 16; i++) mem2[i] = 64'h0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset outputs", {b1.busy_o, b1.done_o, b1.mem_req_o, b1.fifo_w_en_o}, 0);
    chk("reset addr", b1.mem_addr_o, 0);
    RST = 1'b0;

    for (int v = 0; v < 6; v++) begin
      clear_mem1();
      if (tbl[v].widx >= 0) mem1[tbl[v].widx] = tbl[v].wval;
      build_exp(tbl[v].tick);
      chk({tbl[v].name, " model_n"}, expq.size(), tbl[v].n);
      run_scan(tbl[v].tick, tbl[v].mode, 0);
      chk({tbl[v].name, " first"}, (got.size() > 0) ? got[0] : -1, tbl[v].first);
      chk({tbl[v].name, " last"}, (got.size() > 0) ? got[got.size()-1] : -1, tbl[v].last);
      if (v == 1 && got_k.size() == 2) chk("word3 consecutive", got_k[1] - got_k[0], 1);
      if (v == 2) chk("stall en/data", stall_bad, 0);
      if (v == 3 && got_k.size() == 1) chk("last_word done_next", done_k - got_k[0], 1);
      check_scan(tbl[v].name, tbl[v].lat);
    end

    // Reset while two matches are still pending in PUSH
    clear_mem1();
    mem1[2] = 32'h0005_0505;
    build_exp(8'h05);
    @(posedge CLK); #1;
    b1.start_i = 1'b1; b1.tick_i = 8'h05;
    @(posedge CLK); #1;
    b1.start_i = 1'b0;
    nwr = 0;
    for (int k = 0; k < 200 && nwr == 0; k++) begin
      @(negedge CLK);
      if (b1.fifo_w_en_o) nwr++;
    end
    chk("rst first write seen", nwr, 1);
    #1 RST = 1'b1;
    #1;
    chk("rst outputs", {b1.busy_o, b1.done_o, b1.mem_req_o, b1.fifo_w_en_o}, 0);
    chk("rst addr", b1.mem_addr_o, 0);
`ifdef SPIKE_SCAN_FILTER_CNT_EN
    chk("rst cnt", int'(b1.spike_cnt_o), 0);
`endif
    @(posedge CLK); #1;
    RST = 1'b0;
    nwr = 0; m = 0;
    repeat (20) begin
      @(negedge CLK);
      if (b1.fifo_w_en_o) nwr++;
      if (b1.busy_o || b1.mem_req_o) m++;
    end
    chk("rst no writes after", nwr, 0);
    chk("rst stays idle", m, 0);
    run_scan(8'h05, 0, 0);
    check_scan("rescan", 128 + 3);

    // Random memory contents, ticks and backpressure
    for (int r = 0; r < 5; r++) begin
      logic [7:0] t;
      logic [31:0] w;
      t = 8'($urandom);
      for (int i = 0; i < int'(WORDS); i++) begin
        w = $urandom;
        for (int s = 0; s < int'(SLOTS); s++) if ($urandom_range(7) == 0) w[s*8 +: 8] = t;
        mem1[i] = w;
      end
      build_exp(t);
      if (r == 4) begin
        run_scan(t, 0, 0);
        check_scan("rand nostall", 2 * WORDS + expq.size());
      end else begin
        run_scan(t, 1, 30);
        check_scan("rand", -1);
      end
    end

    // Wide configuration: 64-bit words, 16-bit slots, 64 neurons
    mem2[1][2*16 +: 16] = 16'h1234;
    @(posedge CLK); #1;
    b2.start_i = 1'b1; b2.tick_i = 16'h1234;
    @(posedge CLK); #1;
    b2.start_i = 1'b0;
    nwr = 0; wdata = -1; req2 = 0; dk2 = 0;
    for (int k = 1; k <= 500; k++) begin
      @(negedge CLK);
      if (b2.mem_req_o) req2++;
      if (b2.fifo_w_en_o) begin nwr++; wdata = int'(b2.fifo_w_data_o); end
      if (b2.done_o) begin dk2 = k; break; end
    end
    chk("wide done_seen", (dk2 != 0), 1);
    chk("wide writes", nwr, 1);
    chk("wide index", wdata, 6);
    chk("wide req_count", req2, 16);
    chk("wide latency", dk2 - 1, 2 * 16 + 1);
    b2.next_tick_i = 1'b1;
    @(posedge CLK); #1;
    b2.next_tick_i = 1'b0;
    @(negedge CLK);
    chk("wide idle_after_next", {b2.done_o, b2.busy_o}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spike_scan_filter.md
Name: spike_scan_filter

Overview:
- Parametrised successor to the tick-matching spike filter. Scans the per-neuron spike-time memory one word at a time.
- Each word packs SLOTS = WORD_W/SLOT_W slots. Each slot is compared against the current tick. Every matching neuron index is pushed into the event FIFO, one per cycle, with full-FIFO backpressure.
- Sits between the tick generator, the spike-time SRAM (1-cycle read latency) and the spike-core event FIFO.

Parameters:
- N, 256, neuron count; power of 2, multiple of SLOTS.
- WORD_W, 32, memory word width in bits.
- SLOT_W, 8, spike-time/tick width; WORD_W must be a multiple of SLOT_W.
- Derived: SLOTS = WORD_W/SLOT_W; WORDS = N/SLOTS; AW = $clog2(WORDS); IW = $clog2(N).

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- start_i  in  1  start one scan; sampled only in IDLE
- tick_i  in  SLOT_W  current tick; held stable by the tick generator for the whole scan
- next_tick_i  in  1  single-cycle pulse; releases DONE
- mem_req_o  out  1  read request to spike-time SRAM
- mem_addr_o  out  AW  word address
- mem_rdata_i  in  WORD_W  read data, valid the cycle after mem_req_o; slot k = bits [k*SLOT_W +: SLOT_W]
- fifo_w_en_o  out  1  FIFO write strobe
- fifo_w_data_o  out  IW  neuron index = word*SLOTS + slot
- fifo_full_i  in  1  FIFO full; no write is issued while high
- busy_o  out  1  high in every state except IDLE and DONE
- done_o  out  1  scan complete; high in DONE

Behaviour:
- Reset (async, RST=1): state IDLE, word counter 0, match mask 0. All outputs 0.
- States: IDLE, REQ, CMP, PUSH, DONE.
- IDLE
  - start_i=1 -> REQ, word counter cleared to 0.
  - Otherwise stay.
- REQ
  - mem_req_o=1, mem_addr_o=word counter.
  - -> CMP unconditionally.
- CMP
  - Data valid. Register mask[k] = (slot k == tick_i) for all k.
  - Mask nonzero -> PUSH.
  - Mask zero and word = WORDS-1 -> DONE.
  - Mask zero otherwise -> word+1, REQ.
- PUSH
  - p = lowest set bit of mask.
  - fifo_w_en_o = !fifo_full_i; fifo_w_data_o = word*SLOTS + p, combinational. The data is stable while stalled.
  - Write accepted: clear mask[p].
    - If that was the last set bit and word = WORDS-1 -> DONE.
    - If that was the last set bit otherwise -> word+1, REQ.
    - Else stay in PUSH.
  - fifo_full_i=1: hold state, mask and word. No write.
- DONE
  - done_o=1.
  - next_tick_i=1 -> IDLE.
- Throughput:
  - Match-free word: 2 cycles.
  - Word with m matches: 2+m cycles, plus stall cycles.
- Ordering: indices are strictly ascending within a scan.
- Width rules: word counter AW bits; index = {word, p[$clog2(SLOTS)-1:0]}. No arithmetic overflow.
- start_i outside IDLE is ignored. next_tick_i outside DONE is ignored.
- tick_i change mid-scan is unsupported. A mask already registered is unaffected by the change.
- RST mid-scan: immediate return to IDLE. No partial write is emitted after reset deassertion.
- Simultaneous fifo_full_i rise and last push: no write that cycle; the push retries.

Optional Feature:
- Macro SPIKE_SCAN_FILTER_CNT_EN.
- Defined:
  - Extra output spike_cnt_o, width IW+1. Counts accepted FIFO writes in the current scan.
  - Cleared to 0 on the IDLE->REQ transition and on reset.
  - Saturates at N. Holds its value in DONE.
- Undefined: port and counter absent. Behaviour otherwise identical.

Test Plan:
- Defaults, all words 0x00000000, tick_i=0x05, start pulse:
  - exactly 64 REQ cycles, no FIFO writes.
  - done_o rises 128 cycles after start sampled.
  - IDLE after next_tick_i.
- Word 3 = 0x05000500, others 0, tick 0x05:
  - writes 13 then 15 on consecutive cycles.
  - CNT_EN: spike_cnt_o=2 in DONE.
- Word 0 = 0x05050505, tick 0x05, fifo_full_i high for cycles 3-6 of the scan:
  - writes 0,1,2,3 in order.
  - no fifo_w_en_o while full; fifo_w_data_o stable across the stall.
- Last word (63) = 0x05xxxxxx, tick 0x05:
  - single write of 255.
  - DONE entered the cycle after that write, no extra REQ.
- RST pulsed in PUSH with two pending matches:
  - outputs 0 immediately.
  - no writes after release.
  - a new start rescans from word 0.
- WORD_W=64, SLOT_W=16, N=64; word 1 slot 2 = tick:
  - single write of index 6.
  - 16 words scanned.
